// File: rtl/buzz_arbiter.sv
`default_nettype none
// ==========================================================================================
// buzz_arbiter: debounced four-contestant buzzer arbiter; BUZZ_FOUL_EN adds early-press lockout
// Rev 1.0
// ==========================================================================================
module buzz_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ARM_TIMEOUT_S   = 10
) (
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic       Clk1Hz,
    input  logic [3:0] btn,
    input  logic       hostArm,
    input  logic       hostClear,
    input  logic       answerDone,
    output logic       answerSig,
    output logic       timeoutSig,
    output logic       armed,
    output logic       locked,
    output logic [1:0] winner,
    output logic       winnerValid,
    output logic [3:0] foul
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = (ARM_TIMEOUT_S > 0) ? $clog2(ARM_TIMEOUT_S + 1) : 1;
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'((ARM_TIMEOUT_S > 0) ? ARM_TIMEOUT_S - 1 : 0);
    localparam logic [TICK_W-1:0] TICK_MAX   = '1;
    localparam bit                TIMEOUT_EN = (ARM_TIMEOUT_S != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [3:0] stable;
    logic [3:0] stable_q;
    logic [3:0] press;
    logic [3:0] eligible;
    logic [1:0] first_idx;

    state_t            state;
    state_t            state_nx;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_nx;
    logic [1:0]        winner_nx;
    logic              answer_nx;
    logic              timeout_nx;
    logic              timeout_hit;

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            sync_a   <= 4'b0000;
            sync_b   <= 4'b0000;
            stable_q <= 4'b0000;
        end else begin
            sync_a   <= btn;
            sync_b   <= sync_a;
            stable_q <= stable;
        end
    end

    // The counter only ever runs while the synchronized level disagrees with the stable one.
    for (genvar i = 0; i < 4; i++) begin : g_button
        logic [DB_W-1:0] db_cnt;
        logic            level;

        always_ff @(posedge Clk100M or posedge Reset) begin
            if (Reset) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (sync_b[i] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        assign stable[i] = level;
    end

    assign press    = stable & ~stable_q;
    assign eligible = press & ~foul;

    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                first_idx = 2'(i);
            end
        end
    end

    assign timeout_hit = TIMEOUT_EN && (tick_cnt == TICK_LAST);

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        winner_nx   = winner;
        answer_nx   = 1'b0;
        timeout_nx  = 1'b0;
        if (hostClear) begin
            state_nx    = S_IDLE;
            tick_cnt_nx = '0;
            winner_nx   = 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hostArm) begin
                        state_nx    = S_ARMED;
                        tick_cnt_nx = '0;
                    end
                end
                S_ARMED: begin
                    // A press beats a coincident final tick.
                    if (|eligible) begin
                        state_nx  = S_LOCKED;
                        winner_nx = first_idx;
                        answer_nx = 1'b1;
                    end else if (Clk1Hz) begin
                        if (timeout_hit) begin
                            state_nx   = S_IDLE;
                            timeout_nx = 1'b1;
                        end else if (tick_cnt != TICK_MAX) begin
                            tick_cnt_nx = tick_cnt + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (answerDone) begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            winner      <= 2'd0;
            answerSig   <= 1'b0;
            timeoutSig  <= 1'b0;
            armed       <= 1'b0;
            locked      <= 1'b0;
            winnerValid <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            winner      <= winner_nx;
            answerSig   <= answer_nx;
            timeoutSig  <= timeout_nx;
            armed       <= (state_nx == S_ARMED);
            locked      <= (state_nx == S_LOCKED);
            winnerValid <= (state_nx == S_LOCKED);
        end
    end

`ifdef BUZZ_FOUL_EN
    logic [3:0] foul_nx;

    // A timeout exit keeps the flags, so early buzzers stay locked out of the re-armed round.
    always_comb begin
        foul_nx = foul;
        if (hostClear) begin
            foul_nx = 4'b0000;
        end else if (state == S_IDLE) begin
            foul_nx = foul | press;
        end else if ((state == S_LOCKED) && answerDone) begin
            foul_nx = 4'b0000;
        end
    end

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            foul <= 4'b0000;
        end else begin
            foul <= foul_nx;
        end
    end
`else
    assign foul = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: doc/buzz_arbiter.md
# buzz_arbiter

Contestant buzzer front end for the quiz timer. Debounces four contestant buttons, arbitrates the first valid press while a round is armed, and emits the single-cycle `answerSig` pulse that starts the downstream answer-period stage. The block returns to idle when that stage reports completion on `answerDone`. Optionally, it locks out contestants who buzz early.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: a synchronized button level must differ from its stable level for this many consecutive cycles before the stable level flips. Range 1 to 2^24-1.
- `ARM_TIMEOUT_S`, 10: number of `Clk1Hz` ticks allowed in ARMED before the round is abandoned. A value of 0 disables the timeout.

- `Clk100M` in 1: system clock. All flops use its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Clk1Hz` in 1: one-cycle tick strobe, synchronous to `Clk100M`.
- `btn` in 4: raw contestant buttons, asynchronous, active-high.
- `hostArm` in 1: one-cycle synchronous pulse that arms a round.
- `hostClear` in 1: one-cycle synchronous pulse that aborts and clears.
- `answerDone` in 1: pulse from the answer-period stage marking the end of the answer.
- `answerSig` out 1: one-cycle pulse on lock-in.
- `timeoutSig` out 1: one-cycle pulse when an armed round expires.
- `armed` out 1: high while in ARMED.
- `locked` out 1: high while in LOCKED.
- `winner` out 2: index of the locked contestant.
- `winnerValid` out 1: high while in LOCKED.
- `foul` out 4: per-contestant early-press lockout flags.

## Operation
- Per-button front end:
  - 2-flop synchronizer, then a debounce counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever the synchronized level equals the stable level.
  - Stable level flips when the counter reaches `DEBOUNCE_CYCLES`; the counter clears on the same edge.
  - Press event = combinational rising edge of the stable level (stable & ~stable_q). It lasts one cycle.
- State machine, states IDLE, ARMED, LOCKED:
  - IDLE to ARMED on `hostArm`. The tick counter clears on entry.
  - ARMED to LOCKED on any press event from a contestant whose `foul` bit is 0.
    - Winner = lowest index among the simultaneous eligible presses.
    - `winner` is registered and `answerSig` is pulsed.
  - ARMED to IDLE when the tick count reaches `ARM_TIMEOUT_S`. `timeoutSig` is pulsed.
  - LOCKED to IDLE on `answerDone`. `foul` clears.
  - Any state to IDLE on `hostClear`. `foul`, `winner` and the tick counter clear.
  - `hostClear` has priority over every other event in the same cycle.
- In ARMED, the tick counter increments on each `Clk1Hz` and saturates.
- A press and the final tick in the same cycle: the press wins; no timeout.
- `hostArm` outside IDLE is ignored. Press events in LOCKED are ignored.
- `winner` holds its value after LOCKED exits (for display) until `hostClear`, reset, or the next lock-in. `winnerValid` drops on exit.
- Reset values:
  - State IDLE.
  - All outputs 0, `winner` = 0.
  - Synchronizers, stable levels and counters 0.

## Timing
- A raw `btn[i]` rise first sampled at edge k gives a stable-level rise at edge k+1+`DEBOUNCE_CYCLES`.
- In ARMED, `answerSig` is high for exactly the cycle after edge k+2+`DEBOUNCE_CYCLES`. `locked`, `winner` and `winnerValid` update on that same edge.
- `timeoutSig` is high for exactly the cycle after the edge that consumes the `ARM_TIMEOUT_S`-th tick.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- When `Reset` asserts mid-round, outputs clear immediately, asynchronously, with no pulse emitted.

## Configuration
- `BUZZ_FOUL_EN` defined:
  - A press event in IDLE sets `foul[i]`.
  - A fouled contestant is ineligible in the next ARMED round.
  - `foul` clears on `answerDone` exit from LOCKED, on `hostClear` and on `Reset`. A timeout exit keeps `foul`.
  - If all four are fouled, the round can only end by timeout or `hostClear`.
- `BUZZ_FOUL_EN` undefined:
  - `foul` is tied to 4'b0000.
  - Presses in IDLE are ignored.

## Test plan
1. `DEBOUNCE_CYCLES`=4, arm, then `btn`=4'b0100 held. Expect `answerSig` high for 1 cycle, 7 cycles after the first sampling edge; `winner`=2; `winnerValid`=1.
2. Arm, then a 3-cycle glitch on `btn[0]` (shorter than 4). Expect no lock and no `answerSig`.
3. Arm, then `btn`=4'b1010 rising on the same edge. Expect `winner`=1. A later `answerDone` gives `locked`=0, `winner` still 1.
4. `ARM_TIMEOUT_S`=3, arm, 3 ticks with no press. Expect `timeoutSig` 1 cycle, back to IDLE. Repeat with a press completing on the 3rd tick's cycle: expect lock and no timeout.
5. `BUZZ_FOUL_EN` defined: press `btn[3]` in IDLE gives `foul`=4'b1000. Arm, press `btn[3]`: no lock. Press `btn[0]`: `winner`=0.
6. `Reset` asserted, and separately `hostClear` asserted, while LOCKED. Expect all outputs 0 and state IDLE. `hostClear` together with `hostArm` leaves the block in IDLE.
